// File: rtl/complex_divide.sv
// complex_divide: 16-by-8 unsigned restoring divider, one quotient bit per cycle, valid/ready handshakes.
// Optional macro COMPLEX_DIVIDE_ZERO_CHK_EN adds div_err and a one-cycle divide-by-zero path.
`default_nettype none

module complex_divide (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_result,
   input  logic [7:0]  in_c,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] quotient,
   output logic [7:0]  remainder,
`ifdef COMPLEX_DIVIDE_ZERO_CHK_EN
   output logic        div_err,
`endif
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] quo_q;
   logic [7:0]  part_rem;
   logic [7:0]  divisor;
   logic [3:0]  count;
   logic [8:0]  shifted;
   logic [7:0]  trial;
   logic        fits;
   logic        accept;

   // The 9-bit shifted partial remainder is compared in full; when it fits the
   // difference is below the divisor, so the low 8 bits of the subtract are exact.
   assign shifted = {part_rem, quo_q[15]};
   assign fits    = (shifted >= {1'b0, divisor});
   assign trial   = shifted[7:0] - divisor;
   assign accept  = in_valid && (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
`ifdef COMPLEX_DIVIDE_ZERO_CHK_EN
               state_nxt = (in_c == 8'd0) ? DONE : CALC;
`else
               state_nxt = CALC;
`endif
            end
         end
         CALC: begin
            busy = 1'b1;
            if (count == 4'd15) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Dividend shifts out MSB first while quotient bits shift in at the bottom.
   always_ff @(posedge clk) begin
      if (rst) begin
         quo_q    <= 16'd0;
         part_rem <= 8'd0;
         divisor  <= 8'd0;
         count    <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  quo_q    <= in_result;
                  part_rem <= 8'd0;
                  divisor  <= in_c;
                  count    <= 4'd0;
`ifdef COMPLEX_DIVIDE_ZERO_CHK_EN
                  if (in_c == 8'd0) begin
                     quo_q    <= 16'hFFFF;
                     part_rem <= in_result[7:0];
                  end
`endif
               end
            end
            CALC: begin
               quo_q    <= {quo_q[14:0], fits};
               part_rem <= fits ? trial : shifted[7:0];
               count    <= count + 4'd1;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef COMPLEX_DIVIDE_ZERO_CHK_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= (in_c == 8'd0);
      end else if ((state == DONE) && out_ready) begin
         err_q <= 1'b0;
      end
   end

   assign div_err = err_q;
`endif

   assign quotient  = quo_q;
   assign remainder = part_rem;

endmodule

`default_nettype wire
